timer_cfg_sequencer: RTL and testbench
======================================

Name: timer_cfg_sequencer

Overview:
Bus-master controller that drives the timer register block's register port (module_en/wr/addr/wdata/rdata). It accepts a complete timer configuration as one command and writes it into the register map in a fixed order, then starts the timer. While the timer runs, it polls STATUS, clears any set flags by write-1-to-clear, and reports them as events. The block sits between the system control logic and the timer register block and is the sole master of that register port.

Parameters:
POLL_INTERVAL, 16, idle cycles between STATUS reads while running (minimum 1).
PW, 8, width of the poll interval counter; POLL_INTERVAL must be less than 2^PW.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_valid  in  1  configuration command valid
cfg_ready  out  1  sequencer can accept a command; high only in IDLE
cfg_ctrl  in  8  CTRL byte; bit0 (start) is ignored on input
cfg_ctrl_in  in  8  CTRL_IN byte
cfg_ctrl_out  in  8  CTRL_OUT byte
cfg_init  in  8  CNT_INIT value
cfg_min  in  8  CNT_MIN value
cfg_max  in  8  CNT_MAX value
cfg_match0  in  8  MATCH_0 value
cfg_match1  in  8  MATCH_1 value
stop_req  in  1  single-cycle request to stop a running timer
busy  out  1  high in any state other than IDLE
evt_valid  out  1  one-cycle pulse when nonzero status flags were captured
evt_flags  out  3  {match1, match0, overflow} captured with evt_valid
module_en  out  1  register port enable
wr  out  1  register port write (1) / read (0)
addr  out  6  register port address
wdata  out  8  register port write data
rdata  in  8  register port read data (combinational, valid in the same cycle)

Behaviour:
- Reset values: cfg_ready=1, busy=0, evt_valid=0, evt_flags=0, module_en=0, wr=0, addr=0, wdata=0. State is IDLE and stop_pending is cleared.
- All register-port outputs are driven from flops. Each bus access lasts exactly one cycle with module_en=1. module_en=0 in every other cycle.
- States: IDLE, PROG, WAIT, READ, CLEAR, STOP.
- IDLE: on cfg_valid & cfg_ready, latch all cfg_* fields into shadow flops, set step=0, and go to PROG. cfg_valid while not in IDLE is ignored.
- PROG issues one write per cycle, 10 cycles total, in this order of addr/wdata:
  - 0x0 / ctrl&0xFE
  - 0x1 / ctrl_in
  - 0x2 / ctrl_out
  - 0x8 / init
  - 0x9 / min
  - 0xA / max
  - 0xC / match0
  - 0xD / match1
  - 0x4 / 0x07 (clears stale flags)
  - 0x0 / ctrl|0x01 (start)
- After the last PROG write: go to STOP if stop_pending is set, otherwise load the poll counter with POLL_INTERVAL-1 and go to WAIT.
- WAIT: decrement the poll counter each cycle. At 0, go to READ.
- READ: one read cycle (module_en=1, wr=0, addr=0x4). Sample rdata[2:0] at the end of that cycle.
  - Sample nonzero: go to CLEAR.
  - Sample zero: reload the counter and return to WAIT.
- CLEAR: write addr=0x4, wdata={5'b0, sampled}. In the same cycle, evt_valid=1 and evt_flags=sampled. Then reload the counter and go to WAIT.
- A flag that sets between READ and CLEAR is not cleared, because CLEAR writes 1 only to the sampled bits. It is caught on the next poll.
- stop_req:
  - Sampled in PROG: sets stop_pending.
  - Sampled in WAIT: go to STOP on the next cycle.
  - Sampled in READ or CLEAR: sets stop_pending. The access completes, then the sequencer goes to STOP instead of WAIT.
  - Sampled in IDLE or STOP: ignored.
- STOP: write addr=0x0, wdata=ctrl&0xFE (timer halted, configuration retained). Clear stop_pending and go to IDLE.
- The sequencer never reads or writes CNT at addr 0xB.
- Reset asserted mid-sequence: all outputs return to reset values immediately. Any partially issued sequence is abandoned, and no bus cycle is issued in the reset cycle.

Test Plan:
- Program: cfg={ctrl=0x31, ctrl_in=0x20, ctrl_out=0x01, init=0x05, min=0x00, max=0x40, m0=0x10, m1=0x30} -> exactly 10 consecutive write cycles. Addr/wdata are 0/0x30, 1/0x20, 2/0x01, 8/0x05, 9/0x00, A/0x40, C/0x10, D/0x30, 4/0x07, 0/0x31. cfg_ready=0 throughout.
- Poll, no flags: rdata=0x00 on every STATUS read -> reads at addr 0x4 every POLL_INTERVAL+1 cycles, no evt_valid, no writes.
- Flag event: rdata=0x06 on one read -> next cycle is a write to 0x4 with wdata=0x06, evt_valid=1, evt_flags=3'b110. Polling then resumes.
- Stop while waiting: stop_req pulse in WAIT -> next cycle writes 0x0 with wdata=0x30, then busy=0 and cfg_ready=1.
- Stop during PROG: stop_req in the 3rd PROG cycle -> all 10 writes complete, then the STOP write 0/0x30, with no STATUS read.
- Reset mid-PROG: assert rst after the 4th write -> module_en=0 and cfg_ready=1 immediately. A new command restarts programming from addr 0x0.

Source files
------------

// File: rtl/timer_cfg_sequencer.sv
`timescale 1ns/1ps
// timer_cfg_sequencer
//   Sole bus master of the timer register block's register port. It accepts a
//   complete timer configuration as one command, writes it into the register
//   map in a fixed order and starts the timer. While the timer runs it polls
//   STATUS, clears captured flags by write-1-to-clear and reports them as
//   events. A stop request halts the timer while keeping its configuration.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   cfg_valid / cfg_ready  configuration command handshake (ready only in IDLE)
//   cfg_ctrl .. cfg_match1 configuration fields, latched on acceptance
//   stop_req               single-cycle request to stop a running timer
//   busy                   high whenever not IDLE
//   evt_valid / evt_flags  one-cycle event carrying {match1, match0, overflow}
//   module_en, wr, addr,
//   wdata, rdata           register port (rdata is combinational)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a configuration command
//   PROG  | ten back-to-back configuration writes, step selects the register
//   WAIT  | poll interval down-counter running
//   READ  | one STATUS read, flags sampled at the end of the cycle
//   CLEAR | write-1-to-clear of the sampled flags, event reported
//   STOP  | write CTRL with start cleared, then back to IDLE
module timer_cfg_sequencer #(
  parameter int POLL_INTERVAL = 16,
  parameter int PW            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_ctrl,
  input  logic [7:0] cfg_ctrl_in,
  input  logic [7:0] cfg_ctrl_out,
  input  logic [7:0] cfg_init,
  input  logic [7:0] cfg_min,
  input  logic [7:0] cfg_max,
  input  logic [7:0] cfg_match0,
  input  logic [7:0] cfg_match1,
  input  logic       stop_req,
  output logic       busy,
  output logic       evt_valid,
  output logic [2:0] evt_flags,
  output logic       module_en,
  output logic       wr,
  output logic [5:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_PROG, S_WAIT, S_READ, S_CLEAR, S_STOP
  } state_t;

  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_INTERVAL - 1);
  localparam logic [3:0]    LAST_STEP   = 4'd9;
  localparam logic [5:0]    A_CTRL      = 6'h00;
  localparam logic [5:0]    A_STATUS    = 6'h04;

  state_t        state, state_next;
  logic [3:0]    step, step_next;
  logic [PW-1:0] cnt, cnt_next;
  logic          stop_pending, pending_next;
  logic [2:0]    sampled, sampled_next;
  logic          pend_eff;

  logic [7:0] sh_ctrl, sh_ctrl_in, sh_ctrl_out, sh_init;
  logic [7:0] sh_min, sh_max, sh_match0, sh_match1;
  logic [7:0] ctrl_n, ctrl_in_n, ctrl_out_n, init_n;
  logic [7:0] min_n, max_n, match0_n, match1_n;
  logic       load_cfg;

  logic       en_n, wr_n, evt_valid_n;
  logic [5:0] addr_n;
  logic [7:0] wdata_n;
  logic [2:0] evt_flags_n;

  logic unused_rdata;
  assign unused_rdata = ^rdata[7:3];

  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // A stop request seen in the same cycle as a decision counts immediately,
  // so the pending flag never outlives the access that should honour it.
  assign pend_eff = stop_pending | stop_req;

  // Shadow next values feed the registered bus outputs, so the first PROG
  // write can use the command fields in the very cycle they are accepted.
  assign load_cfg   = (state == S_IDLE) && cfg_valid;
  assign ctrl_n     = load_cfg ? cfg_ctrl     : sh_ctrl;
  assign ctrl_in_n  = load_cfg ? cfg_ctrl_in  : sh_ctrl_in;
  assign ctrl_out_n = load_cfg ? cfg_ctrl_out : sh_ctrl_out;
  assign init_n     = load_cfg ? cfg_init     : sh_init;
  assign min_n      = load_cfg ? cfg_min      : sh_min;
  assign max_n      = load_cfg ? cfg_max      : sh_max;
  assign match0_n   = load_cfg ? cfg_match0   : sh_match0;
  assign match1_n   = load_cfg ? cfg_match1   : sh_match1;

  // State register, including all bus outputs (registered from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      step         <= '0;
      cnt          <= '0;
      stop_pending <= 1'b0;
      sampled      <= '0;
      module_en    <= 1'b0;
      wr           <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      evt_valid    <= 1'b0;
      evt_flags    <= '0;
      sh_ctrl      <= '0;
      sh_ctrl_in   <= '0;
      sh_ctrl_out  <= '0;
      sh_init      <= '0;
      sh_min       <= '0;
      sh_max       <= '0;
      sh_match0    <= '0;
      sh_match1    <= '0;
    end else begin
      state        <= state_next;
      step         <= step_next;
      cnt          <= cnt_next;
      stop_pending <= pending_next;
      sampled      <= sampled_next;
      module_en    <= en_n;
      wr           <= wr_n;
      addr         <= addr_n;
      wdata        <= wdata_n;
      evt_valid    <= evt_valid_n;
      evt_flags    <= evt_flags_n;
      sh_ctrl      <= ctrl_n;
      sh_ctrl_in   <= ctrl_in_n;
      sh_ctrl_out  <= ctrl_out_n;
      sh_init      <= init_n;
      sh_min       <= min_n;
      sh_max       <= max_n;
      sh_match0    <= match0_n;
      sh_match1    <= match1_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next   = state;
    step_next    = step;
    cnt_next     = cnt;
    pending_next = stop_pending;
    sampled_next = sampled;
    case (state)
      S_IDLE: begin
        pending_next = 1'b0;
        if (cfg_valid) begin
          state_next = S_PROG;
          step_next  = '0;
        end
      end
      S_PROG: begin
        pending_next = pend_eff;
        if (step == LAST_STEP) begin
          if (pend_eff) begin
            state_next = S_STOP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = POLL_RELOAD;
          end
        end else begin
          step_next = step + 4'd1;
        end
      end
      S_WAIT: begin
        if (stop_req) begin
          state_next = S_STOP;
        end else if (cnt == '0) begin
          state_next = S_READ;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_READ: begin
        pending_next = pend_eff;
        sampled_next = rdata[2:0];
        // Flags take priority: they are cleared and reported before stopping.
        if (rdata[2:0] != 3'b000) begin
          state_next = S_CLEAR;
        end else if (pend_eff) begin
          state_next = S_STOP;
        end else begin
          state_next = S_WAIT;
          cnt_next   = POLL_RELOAD;
        end
      end
      S_CLEAR: begin
        pending_next = pend_eff;
        if (pend_eff) begin
          state_next = S_STOP;
        end else begin
          state_next = S_WAIT;
          cnt_next   = POLL_RELOAD;
        end
      end
      S_STOP: begin
        pending_next = 1'b0;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: bus values for the cycle the next state will occupy.
  always_comb begin
    en_n        = 1'b0;
    wr_n        = 1'b0;
    addr_n      = '0;
    wdata_n     = '0;
    evt_valid_n = 1'b0;
    evt_flags_n = '0;
    case (state_next)
      S_PROG: begin
        en_n = 1'b1;
        wr_n = 1'b1;
        case (step_next)
          4'd0:    begin addr_n = 6'h00; wdata_n = ctrl_n & 8'hFE; end
          4'd1:    begin addr_n = 6'h01; wdata_n = ctrl_in_n;      end
          4'd2:    begin addr_n = 6'h02; wdata_n = ctrl_out_n;     end
          4'd3:    begin addr_n = 6'h08; wdata_n = init_n;         end
          4'd4:    begin addr_n = 6'h09; wdata_n = min_n;          end
          4'd5:    begin addr_n = 6'h0A; wdata_n = max_n;          end
          4'd6:    begin addr_n = 6'h0C; wdata_n = match0_n;       end
          4'd7:    begin addr_n = 6'h0D; wdata_n = match1_n;       end
          4'd8:    begin addr_n = 6'h04; wdata_n = 8'h07;          end
          default: begin addr_n = 6'h00; wdata_n = ctrl_n | 8'h01; end
        endcase
      end
      S_READ: begin
        en_n   = 1'b1;
        addr_n = A_STATUS;
      end
      S_CLEAR: begin
        // Only the sampled bits are cleared; a flag that sets after the read
        // survives and is picked up by the next poll.
        en_n        = 1'b1;
        wr_n        = 1'b1;
        addr_n      = A_STATUS;
        wdata_n     = {5'b0, sampled_next};
        evt_valid_n = 1'b1;
        evt_flags_n = sampled_next;
      end
      S_STOP: begin
        en_n    = 1'b1;
        wr_n    = 1'b1;
        addr_n  = A_CTRL;
        wdata_n = ctrl_n & 8'hFE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
`timescale 1ns/1ps
// Directed bench for timer_cfg_sequencer: programming order, polling cadence,
// flag clear/event, stop in WAIT/PROG/READ and reset in the middle of PROG.
module tb_timer_cfg_sequencer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_ctrl, cfg_ctrl_in, cfg_ctrl_out, cfg_init;
  logic [7:0] cfg_min, cfg_max, cfg_match0, cfg_match1;
  logic       stop_req, busy, evt_valid;
  logic [2:0] evt_flags;
  logic       module_en, wr;
  logic [5:0] addr;
  logic [7:0] wdata, rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] exp_addr [10];
  logic [7:0] exp_wdata[10];

  timer_cfg_sequencer #(.POLL_INTERVAL(P), .PW(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ctrl(cfg_ctrl), .cfg_ctrl_in(cfg_ctrl_in), .cfg_ctrl_out(cfg_ctrl_out),
    .cfg_init(cfg_init), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_match0(cfg_match0), .cfg_match1(cfg_match1),
    .stop_req(stop_req), .busy(busy),
    .evt_valid(evt_valid), .evt_flags(evt_flags),
    .module_en(module_en), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a command for one cycle and build the expected write sequence.
  task automatic send_cfg(input logic [7:0] c, ci, co, ini, mn, mx, m0, m1);
    cfg_ctrl = c; cfg_ctrl_in = ci; cfg_ctrl_out = co; cfg_init = ini;
    cfg_min = mn; cfg_max = mx; cfg_match0 = m0; cfg_match1 = m1;
    exp_wdata[0] = c & 8'hFE; exp_wdata[1] = ci; exp_wdata[2] = co;
    exp_wdata[3] = ini; exp_wdata[4] = mn; exp_wdata[5] = mx;
    exp_wdata[6] = m0; exp_wdata[7] = m1; exp_wdata[8] = 8'h07;
    exp_wdata[9] = c | 8'h01;
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
    cfg_ctrl = 8'hFF; cfg_ctrl_in = 8'hFF; cfg_ctrl_out = 8'hFF; cfg_init = 8'hFF;
    cfg_min = 8'hFF; cfg_max = 8'hFF; cfg_match0 = 8'hFF; cfg_match1 = 8'hFF;
  endtask

  task automatic check_write(input int i);
    chk($sformatf("prog%0d_en", i), 32'(module_en), 32'd1);
    chk($sformatf("prog%0d_wr", i), 32'(wr), 32'd1);
    chk($sformatf("prog%0d_addr", i), 32'(addr), 32'(exp_addr[i]));
    chk($sformatf("prog%0d_wdata", i), 32'(wdata), 32'(exp_wdata[i]));
    chk($sformatf("prog%0d_ready", i), 32'(cfg_ready), 32'd0);
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (!module_en && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) chk("timeout_wait_en", 32'd0, 32'd1);
  endtask

  task automatic check_stop_write(input string tag, input logic [7:0] exp_wd);
    chk({tag, "_en"}, 32'(module_en), 32'd1);
    chk({tag, "_wr"}, 32'(wr), 32'd1);
    chk({tag, "_addr"}, 32'(addr), 32'h00);
    chk({tag, "_wdata"}, 32'(wdata), 32'(exp_wd));
    tick;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_idle_en"}, 32'(module_en), 32'd0);
  endtask

  initial begin
    int n;
    exp_addr[0] = 6'h00; exp_addr[1] = 6'h01; exp_addr[2] = 6'h02;
    exp_addr[3] = 6'h08; exp_addr[4] = 6'h09; exp_addr[5] = 6'h0A;
    exp_addr[6] = 6'h0C; exp_addr[7] = 6'h0D; exp_addr[8] = 6'h04;
    exp_addr[9] = 6'h00;
    rst = 1'b1; cfg_valid = 1'b0; stop_req = 1'b0; rdata = 8'h00;
    cfg_ctrl = 8'h00; cfg_ctrl_in = 8'h00; cfg_ctrl_out = 8'h00; cfg_init = 8'h00;
    cfg_min = 8'h00; cfg_max = 8'h00; cfg_match0 = 8'h00; cfg_match1 = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_evt", 32'(evt_valid), 32'd0);
    chk("rst_flags", 32'(evt_flags), 32'd0);
    chk("rst_en", 32'(module_en), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    rst = 1'b0;
    tick;

    // Program cfg1: 10 back-to-back writes
    send_cfg(8'h31, 8'h20, 8'h01, 8'h05, 8'h00, 8'h40, 8'h10, 8'h30);
    for (int i = 0; i < 10; i++) begin
      check_write(i);
      tick;
    end
    chk("wait_en", 32'(module_en), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);

    // Poll with no flags
    wait_en(n);
    chk("first_read_gap", 32'(n), 32'(P));
    chk("read_addr", 32'(addr), 32'h04);
    chk("read_wr", 32'(wr), 32'd0);
    tick;
    wait_en(n);
    chk("poll_period", 32'(n + 1), 32'(P + 1));
    chk("poll_addr", 32'(addr), 32'h04);
    chk("poll_wr", 32'(wr), 32'd0);
    chk("poll_evt", 32'(evt_valid), 32'd0);

    // Flag event: flags 3'b110 seen on this read
    rdata = 8'h06;
    tick;
    rdata = 8'h00;
    chk("clr_en", 32'(module_en), 32'd1);
    chk("clr_wr", 32'(wr), 32'd1);
    chk("clr_addr", 32'(addr), 32'h04);
    chk("clr_wdata", 32'(wdata), 32'h06);
    chk("clr_evt", 32'(evt_valid), 32'd1);
    chk("clr_flags", 32'(evt_flags), 32'b110);
    tick;
    chk("post_clr_evt", 32'(evt_valid), 32'd0);
    chk("post_clr_en", 32'(module_en), 32'd0);
    wait_en(n);
    chk("resume_gap", 32'(n + 1), 32'(P + 1));
    chk("resume_wr", 32'(wr), 32'd0);

    // Stop while waiting
    tick;
    stop_req = 1'b1;
    tick;
    stop_req = 1'b0;
    check_stop_write("stop_wait", 8'h30);

    // Stop during the 3rd PROG cycle
    send_cfg(8'h31, 8'h20, 8'h01, 8'h05, 8'h00, 8'h40, 8'h10, 8'h30);
    for (int i = 0; i < 10; i++) begin
      check_write(i);
      stop_req = (i == 2);
      tick;
      stop_req = 1'b0;
    end
    check_stop_write("stop_prog", 8'h30);

    // Second configuration; pending stop must not carry over
    send_cfg(8'hA5, 8'h0C, 8'h02, 8'h7F, 8'h03, 8'hF0, 8'h55, 8'hAA);
    for (int i = 0; i < 10; i++) begin
      check_write(i);
      tick;
    end
    wait_en(n);
    chk("cfg2_read_gap", 32'(n), 32'(P));
    chk("cfg2_read_wr", 32'(wr), 32'd0);

    // Stop in READ with overflow flag: clear and report, then stop
    rdata = 8'h01;
    stop_req = 1'b1;
    tick;
    stop_req = 1'b0;
    rdata = 8'h00;
    chk("rdstop_clr_addr", 32'(addr), 32'h04);
    chk("rdstop_clr_wdata", 32'(wdata), 32'h01);
    chk("rdstop_evt", 32'(evt_valid), 32'd1);
    chk("rdstop_flags", 32'(evt_flags), 32'b001);
    tick;
    check_stop_write("stop_read", 8'hA4);

    // Reset mid-PROG after the 4th write
    send_cfg(8'h31, 8'h20, 8'h01, 8'h05, 8'h00, 8'h40, 8'h10, 8'h30);
    for (int i = 0; i < 4; i++) begin
      check_write(i);
      tick;
    end
    rst = 1'b1;
    #1;
    chk("midrst_en", 32'(module_en), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    tick;
    chk("midrst_hold_en", 32'(module_en), 32'd0);
    rst = 1'b0;
    tick;
    send_cfg(8'h31, 8'h20, 8'h01, 8'h05, 8'h00, 8'h40, 8'h10, 8'h30);
    for (int i = 0; i < 10; i++) begin
      check_write(i);
      tick;
    end
    chk("restart_wait_en", 32'(module_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
